// File: rtl/somador_acc_if.sv
// Command/result bus of the registered adder-accumulator.
// Carries the producer-side command handshake and the consumer-side result handshake.
// The slave modport is the arithmetic block. The master modport drives commands and consumes results.
interface somador_acc_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   // Producer -> block command channel
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] ia;
   logic [WIDTH-1:0] ib;
   logic [1:0]       mode;

   // Block -> consumer result channel
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             carry;
   logic             overflow;

   // Status visible at all times
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] op_count;

   modport slave (
      input  in_valid, ia, ib, mode, out_ready,
      output in_ready, out_valid, out, carry, overflow, acc, op_count
   );

   modport master (
      output in_valid, ia, ib, mode, out_ready,
      input  in_ready, out_valid, out, carry, overflow, acc, op_count
   );
endinterface

// File: rtl/somador_acc.sv
// Registered add/sub/accumulate/clear unit with carry, overflow and optional unsigned saturation.
// Latency 1 cycle from accept to result; throughput 1 command per cycle while out_ready is high.
// Backpressure: in_ready = !out_valid || out_ready; a held result and all flags freeze while stalled.
module somador_acc #(
   parameter int WIDTH    = 4,
   parameter int SATURATE = 0,
   parameter int CNT_W    = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   somador_acc_if.slave   bus
);

   localparam logic [1:0] MODE_ADD = 2'b00;
   localparam logic [1:0] MODE_SUB = 2'b01;
   localparam logic [1:0] MODE_ACC = 2'b10;
   localparam logic [1:0] MODE_CLR = 2'b11;

   localparam int             MSB     = WIDTH - 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t state_q, state_d;

   // Result register and architectural state
   logic [WIDTH-1:0] out_q;
   logic             carry_q;
   logic             ovf_q;
   logic [WIDTH-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;

   // Handshake decode
   logic accept;
   logic in_ready_w;

   // Datapath operands and raw WIDTH+1 results
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   diff_w;

   // Next values produced by the current command
   logic [WIDTH-1:0] res_d;
   logic             carry_d;
   logic             ovf_d;
   logic [WIDTH-1:0] acc_d;

   // A stalled consumer only blocks us when we actually hold a result
   assign in_ready_w = (state_q == EMPTY) || bus.out_ready;
   assign accept     = bus.in_valid && in_ready_w;

   // Two-state occupancy FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Two-state occupancy FSM: next state. Accept always leaves us FULL,
   // even when the old result drains in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = FULL;
            end
         end
         FULL: begin
            if (accept) begin
               state_d = FULL;
            end else if (bus.out_ready) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Accumulate reuses the adder with the accumulator standing in for operand A
   always_comb begin
      opa = bus.ia;
      opb = bus.ib;
      if (bus.mode == MODE_ACC) begin
         opa = acc_q;
         opb = bus.ia;
      end
   end

   assign sum_w  = {1'b0, opa} + {1'b0, opb};
   assign diff_w = {1'b0, opa} - {1'b0, opb};

   // Result, flags and accumulator update for the presented command.
   // Flags always report the raw arithmetic condition, saturation only clamps the value.
   always_comb begin
      res_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      acc_d   = acc_q;
      case (bus.mode)
         MODE_ADD, MODE_ACC: begin
            res_d   = sum_w[MSB:0];
            carry_d = sum_w[WIDTH];
            ovf_d   = (opa[MSB] == opb[MSB]) && (sum_w[MSB] != opa[MSB]);
            if ((SATURATE != 0) && sum_w[WIDTH]) begin
               res_d = '1;
            end
            if (bus.mode == MODE_ACC) begin
               acc_d = res_d;
            end
         end
         MODE_SUB: begin
            res_d   = diff_w[MSB:0];
            // The borrow out of the extended subtraction is exactly ia < ib unsigned
            carry_d = diff_w[WIDTH];
            ovf_d   = (opa[MSB] != opb[MSB]) && (diff_w[MSB] != opa[MSB]);
            if ((SATURATE != 0) && diff_w[WIDTH]) begin
               res_d = '0;
            end
         end
         MODE_CLR: begin
            res_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            acc_d   = '0;
         end
         default: begin
            res_d = '0;
         end
      endcase
   end

   // Result register: loads only on accept so it stays stable under backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         out_q   <= res_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   // Accumulator: touched only by accepted accumulate/clear commands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (accept && bus.mode[1]) begin
         acc_q <= acc_d;
      end
   end

   // Accepted-command counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= cnt_q + CNT_ONE;
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = (state_q == FULL);
   assign bus.out       = out_q;
   assign bus.carry     = carry_q;
   assign bus.overflow  = ovf_q;
   assign bus.acc       = acc_q;
   assign bus.op_count  = cnt_q;

endmodule

// File: doc/somador_acc.md
Name: somador_acc

Overview:
Parametrised, registered successor to the 4-bit combinational somador. It performs add, subtract, accumulate and clear on WIDTH-bit operands, with carry/borrow and signed-overflow flags and optional unsigned saturation. Results are held in a one-entry output register behind a valid/ready handshake on both sides. The block sits between operand producers (register file or lab stimulus logic) and any downstream consumer that can stall.

Parameters:
WIDTH, 4, operand/result width in bits (>= 2)
SATURATE, 0, 1 = unsigned saturation on add/accumulate/subtract; 0 = wrap-around
CNT_W, 8, width of the completed-operation counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand/command valid
in_ready  out  1  block can accept a command this cycle
ia  in  WIDTH  operand A
ib  in  WIDTH  operand B (ignored in accumulate/clear)
mode  in  2  00 add ia+ib; 01 sub ia-ib; 10 accumulate acc+ia; 11 clear acc
out_valid  out  1  result register holds an unconsumed result
out_ready  in  1  consumer accepts the result this cycle
out  out  WIDTH  result
carry  out  1  add/acc: carry-out; sub: borrow (ia<ib unsigned); clear: 0
overflow  out  1  two's-complement overflow of the operation; clear: 0
acc  out  WIDTH  current accumulator value (registered)
op_count  out  CNT_W  number of accepted commands, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst_n=0): out=0, carry=0, overflow=0, out_valid=0, acc=0, op_count=0. in_ready=1 once rst_n=1. Reset mid-operation discards any held result; no partial state survives.
- Two states, EMPTY (out_valid=0) and FULL (out_valid=1). in_ready = !out_valid || out_ready (combinational pass-through of out_ready).
- Accept: in_valid && in_ready at a rising edge. The result, flags and out_valid=1 register on that edge, so latency is 1 cycle and throughput is 1 per cycle while out_ready=1.
- Consume: out_valid && out_ready with no simultaneous accept -> out_valid=0 (FULL->EMPTY). When consume and accept happen in the same cycle, the new result replaces the old one and out_valid stays 1.
- FULL && !out_ready: in_ready=0. out, carry, overflow and out_valid hold stable. in_valid is ignored and nothing changes.
- Arithmetic is computed at WIDTH+1 bits. out = low WIDTH bits. carry = bit WIDTH for add/acc, and = borrow for sub. overflow is set when the operand signs match (add/acc) or differ (sub) and the result sign differs from A's sign.
- Accumulate: acc_next = acc + ia. Both out and acc take the new (saturated if SATURATE=1) value. Clear: acc=0, out=0, flags=0, and it still produces a result (out_valid=1).
- acc changes only on an accepted mode 10/11 command. Add and sub never modify acc.
- SATURATE=1: on add/acc carry, out (and acc) = all-ones. On sub borrow, out = 0. carry/overflow still report the raw condition.
- op_count increments by 1 on every accepted command of any mode, and wraps from 2^CNT_W-1 to 0.
- in_valid and operands need not be held after acceptance. Commands presented while in_ready=0 are not consumed, and the producer must hold them.

Test Plan:
- WIDTH=4, out_ready=1: add 0+1, 2+1, 3+1, A+1, A+2, A+3 in consecutive cycles -> out=1,3,4,B,C,D one cycle after each accept, carry=0, op_count=6.
- Add F+1 -> out=0, carry=1, overflow=0. Add 7+1 -> out=8, carry=0, overflow=1. With SATURATE=1, F+1 -> out=F, carry=1.
- Sub 2-3 -> out=F, carry(borrow)=1. Sub 8-1 -> out=7, overflow=1. Sub 5-5 -> out=0, carry=0.
- Clear, then accumulate 3, 4, 9 -> acc=3, 7, 0 with carry=1 on the third. Then clear -> acc=0, out_valid pulses with out=0.
- Backpressure: accept add 1+1, hold out_ready=0 for 3 cycles while in_valid=1 with 2+2 -> in_ready=0, out=2 stable. Raise out_ready -> 2 consumed and 2+2 accepted the same cycle, out=4 next cycle.
- Assert rst_n=0 asynchronously between clock edges while FULL with acc=5 -> out_valid, out, acc and op_count go to 0 immediately. After release, in_ready=1.
